mfp_ahb_dump_reader: RTL and testbench

MFP_AHB_DUMP_READER -- requirements
Module: mfp_ahb_dump_reader

---
 rtl/mfp_ahb_dump_reader.sv | 156 +++++++++++++++
 tb/tb_mfp_ahb_dump_reader.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_dump_reader.sv
// mfp_ahb_dump_reader
// Reads a block of 32-bit words from an AHB-lite slave, one SINGLE read at a
// time, and streams each word out as four bytes, least significant first.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; zero-length requests complete here
// ADDR  | address phase, NONSEQ on the bus until HREADY is seen
// DATA  | data phase, waiting for HREADY to capture HRDATA or an ERROR
// SEND  | presenting buffer bytes [index] to the consumer
module mfp_ahb_dump_reader #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [31:0]          start_address,
    input  logic [LEN_WIDTH-1:0] word_count,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [7:0]           out_byte,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          HADDR,
    output logic [2:0]           HBURST,
    output logic                 HMASTLOCK,
    output logic [3:0]           HPROT,
    output logic [2:0]           HSIZE,
    output logic [1:0]           HTRANS,
    output logic [31:0]          HWDATA,
    output logic                 HWRITE,
    input  logic [31:0]          HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t               state;
    logic [31:0]          addr;
    logic [LEN_WIDTH-1:0] remaining;
    logic [1:0]           index;
    logic [31:0]          buffer;

    logic [31:0]          addr_next;
    logic [1:0]           index_next;
    logic [7:0]           byte_next;
    logic                 unused_bits;

    // Read-only single-beat master: the remaining AHB controls are constant.
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = 4'b0000;
    assign HSIZE     = 3'b010;
    assign HWRITE    = 1'b0;
    assign HWDATA    = 32'h0000_0000;

    // Word address advance wraps inside the 29-bit field that reaches HADDR.
    assign addr_next   = {addr[31:29], addr[28:0] + 29'd4};
    assign index_next  = index + 2'd1;
    assign byte_next   = buffer[{index_next, 3'b000} +: 8];
    assign unused_bits = ^start_address[1:0];

    // Sequencer: bus handshake, byte streaming and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr      <= 32'h0000_0000;
            remaining <= '0;
            index     <= 2'd0;
            buffer    <= 32'h0000_0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            out_byte  <= 8'h00;
            out_valid <= 1'b0;
            HADDR     <= 32'h0000_0000;
            HTRANS    <= HTRANS_IDLE;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        if (word_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr      <= {start_address[31:2], 2'b00};
                            remaining <= word_count;
                            HADDR     <= {3'b000, start_address[28:2], 2'b00};
                            HTRANS    <= HTRANS_NONSEQ;
                            busy      <= 1'b1;
                            state     <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (HREADY) begin
                        HTRANS <= HTRANS_IDLE;
                        state  <= DATA;
                    end
                end
                DATA: begin
                    // The first (HREADY=0) cycle of an ERROR response is ignored.
                    if (HREADY) begin
                        if (HRESP) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            buffer    <= HRDATA;
                            index     <= 2'd0;
                            out_byte  <= HRDATA[7:0];
                            out_valid <= 1'b1;
                            state     <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        index    <= index_next;
                        out_byte <= byte_next;
                        if (index == 2'd3) begin
                            out_valid <= 1'b0;
                            remaining <= remaining - 1'b1;
                            if (remaining == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                addr   <= addr_next;
                                HADDR  <= {3'b000, addr_next[28:2], 2'b00};
                                HTRANS <= HTRANS_NONSEQ;
                                state  <= ADDR;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_ahb_dump_reader.sv
// Bench for mfp_ahb_dump_reader: behavioural AHB slave, byte consumer with a
// scoreboard queue, and one task per scenario.
`timescale 1ns/1ps
module tb_mfp_ahb_dump_reader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] start_address;
    logic [15:0] word_count;
    logic        busy, done, error;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] addr_log[$];
    int          addr_waits = 0;
    int          data_waits = 0;
    int          err_word   = 0;
    int          ready_mode = 0;
    int          done_cyc;
    int          done_cnt;
    logic        err_at1;
    logic        busy_at1;

    always #5 clock = ~clock;

    mfp_ahb_dump_reader #(.LEN_WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .start_address(start_address), .word_count(word_count),
        .busy(busy), .done(done), .error(error),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    // Slave memory contents: one fixed word, the rest a scrambled address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h4433_2211;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    // Expected byte stream for n words starting at byte address sa.
    task automatic push_words(input logic [31:0] sa, input int n);
        logic [31:0] a;
        logic [31:0] h;
        logic [31:0] w;
        a = {sa[31:2], 2'b00};
        for (int i = 0; i < n; i++) begin
            h = {3'b000, a[28:2], 2'b00};
            w = mem_word(h);
            for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
            a[28:0] = a[28:0] + 29'd4;
        end
    endtask

    task automatic slave_proc();
        int          a_cnt = 0;
        int          d_cnt = 0;
        int          err_step = 0;
        int          s_word = 0;
        bit          s_phase = 0;
        logic [31:0] s_addr = 0;
        logic [31:0] held = 0;
        forever begin
            @(negedge clock);
            HRESP  = 1'b0;
            HREADY = 1'b1;
            if (!reset_n) begin
                a_cnt = 0; d_cnt = 0; err_step = 0; s_word = 0; s_phase = 0;
            end else if (!s_phase) begin
                if (!busy) s_word = 0;
                if (a_cnt > 0) begin
                    checks++;
                    if (HTRANS !== 2'b10 || HADDR !== held) begin
                        errors++;
                        $display("FAIL addr_hold: HTRANS=%b HADDR=%h required 10 %h", HTRANS, HADDR, held);
                    end
                end
                if (HTRANS == 2'b10) begin
                    if (a_cnt < addr_waits) begin
                        HREADY = 1'b0;
                        held   = HADDR;
                        a_cnt++;
                    end else begin
                        s_addr  = HADDR;
                        a_cnt   = 0;
                        s_phase = 1;
                        s_word++;
                    end
                end else begin
                    a_cnt = 0;
                end
            end else begin
                if (d_cnt < data_waits) begin
                    HREADY = 1'b0;
                    d_cnt++;
                end else if (s_word == err_word && err_step == 0) begin
                    HRESP    = 1'b1;
                    HREADY   = 1'b0;
                    err_step = 1;
                end else if (s_word == err_word) begin
                    HRESP    = 1'b1;
                    err_step = 0;
                    d_cnt    = 0;
                    s_phase  = 0;
                end else begin
                    HRDATA  = mem_word(s_addr);
                    d_cnt   = 0;
                    s_phase = 0;
                end
            end
        end
    endtask

    task automatic consumer_proc();
        logic [7:0] prev = 8'h00;
        logic [7:0] expv;
        bit         stalled = 0;
        forever begin
            @(negedge clock);
            if (ready_mode == 1) out_ready = ~out_ready;
            else out_ready = 1'b1;
            if (!reset_n || !out_valid) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    checks++;
                    if (out_byte !== prev) begin
                        errors++;
                        $display("FAIL stall_hold: out_byte=%h required %h", out_byte, prev);
                    end
                end
                if (out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_byte: out_byte=%h required no byte", out_byte);
                    end else begin
                        expv = exp_q.pop_front();
                        if (out_byte !== expv) begin
                            errors++;
                            $display("FAIL byte: out_byte=%h required %h", out_byte, expv);
                        end
                    end
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prev    = out_byte;
                end
            end
        end
    endtask

    // Starts a dump from a negedge and observes until a few cycles past done.
    task automatic do_dump(input logic [31:0] sa, input logic [15:0] n, input int restart_at);
        bit prev_ns = 0;
        addr_log.delete();
        done_cyc = 0;
        done_cnt = 0;
        start_address = sa;
        word_count    = n;
        start         = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clock);
            start = (c == restart_at);
            if (c == restart_at) begin
                start_address = 32'h0000_3000;
                word_count    = 16'd4;
            end
            if (c == 1) begin
                err_at1  = error;
                busy_at1 = busy;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (HTRANS == 2'b10 && !prev_ns) addr_log.push_back(HADDR);
            prev_ns = (HTRANS == 2'b10);
            if (done_cyc != 0 && c >= done_cyc + 4) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, done, error, out_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/error/valid=%b required 0000", {busy, done, error, out_valid});
        end
        checks++;
        if (out_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_byte: out_byte=%h required 00", out_byte);
        end
        checks++;
        if (HTRANS !== 2'b00 || HADDR !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: HTRANS=%b HADDR=%h required 00 0", HTRANS, HADDR);
        end
        checks++;
        if ({HBURST, HMASTLOCK, HPROT, HSIZE, HWRITE} !== {3'b000, 1'b0, 4'b0000, 3'b010, 1'b0} || HWDATA !== 32'h0) begin
            errors++;
            $display("FAIL tie_offs: got %b/%b/%b/%b/%b/%h", HBURST, HMASTLOCK, HPROT, HSIZE, HWRITE, HWDATA);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single();
        push_words(32'h0000_1002, 1);
        do_dump(32'h0000_1002, 16'd1, 0);
        checks++;
        if (busy_at1 !== 1'b1) begin errors++; $display("FAIL single_busy: got %b required 1", busy_at1); end
        checks++;
        if (done_cyc != 7) begin errors++; $display("FAIL single_done_cycle: got %0d required 7", done_cyc); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL single_done_count: got %0d required 1", done_cnt); end
        checks++;
        if (addr_log.size() != 1 || addr_log[0] !== 32'h0000_1000) begin
            errors++;
            $display("FAIL single_haddr: %0d transfers first %h required 1 at 00001000", addr_log.size(), addr_log[0]);
        end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_end: busy=%b bytes_left=%0d required 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        push_words(32'hBFC0_0000, 2);
        do_dump(32'hBFC0_0000, 16'd2, 0);
        checks++;
        if (done_cyc != 13 || done_cnt != 1) begin
            errors++;
            $display("FAIL b2b_done: cycle %0d count %0d required 13 1", done_cyc, done_cnt);
        end
        checks++;
        if (addr_log.size() != 2 || addr_log[0] !== 32'h1FC0_0000 || addr_log[1] !== 32'h1FC0_0004) begin
            errors++;
            $display("FAIL b2b_haddr: %0d transfers %h %h required 1fc00000 1fc00004", addr_log.size(), addr_log[0], addr_log[1]);
        end
        push_words(32'h7FFF_FFFC, 2);
        do_dump(32'h7FFF_FFFC, 16'd2, 0);
        checks++;
        if (addr_log.size() != 2 || addr_log[0] !== 32'h1FFF_FFFC || addr_log[1] !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_haddr: %0d transfers %h %h required 1ffffffc 00000000", addr_log.size(), addr_log[0], addr_log[1]);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_bytes: left %0d required 0", exp_q.size()); end
    endtask

    task automatic test_wait_states();
        addr_waits = 3;
        data_waits = 2;
        push_words(32'h0000_0400, 2);
        do_dump(32'h0000_0400, 16'd2, 0);
        checks++;
        if (done_cyc != 23 || done_cnt != 1) begin
            errors++;
            $display("FAIL wait_done: cycle %0d count %0d required 23 1", done_cyc, done_cnt);
        end
        checks++;
        if (addr_log.size() != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wait_stream: transfers %0d bytes_left %0d required 2 0", addr_log.size(), exp_q.size());
        end
        addr_waits = 0;
        data_waits = 0;
    endtask

    task automatic test_error();
        err_word = 2;
        push_words(32'h0000_2000, 1);
        do_dump(32'h0000_2000, 16'd3, 0);
        checks++;
        if (done_cyc != 10 || done_cnt != 1) begin
            errors++;
            $display("FAIL err_done: cycle %0d count %0d required 10 1", done_cyc, done_cnt);
        end
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || exp_q.size() != 0 || addr_log.size() != 2) begin
            errors++;
            $display("FAIL err_state: error=%b busy=%b left=%0d transfers=%0d required 1 0 0 2", error, busy, exp_q.size(), addr_log.size());
        end
        repeat (5) @(negedge clock);
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", error); end
        err_word = 0;
        push_words(32'h0000_2100, 1);
        do_dump(32'h0000_2100, 16'd1, 0);
        checks++;
        if (err_at1 !== 1'b0 || error !== 1'b0 || done_cyc != 7) begin
            errors++;
            $display("FAIL err_clear: at1=%b end=%b done_cycle=%0d required 0 0 7", err_at1, error, done_cyc);
        end
    endtask

    task automatic test_ready_toggle();
        ready_mode = 1;
        push_words(32'h0000_3400, 2);
        do_dump(32'h0000_3400, 16'd2, 5);
        checks++;
        if (done_cnt != 1 || done_cyc < 14) begin
            errors++;
            $display("FAIL toggle_done: count %0d cycle %0d required 1 >=14", done_cnt, done_cyc);
        end
        checks++;
        if (addr_log.size() != 2 || exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL toggle_stream: transfers %0d left %0d busy %b required 2 0 0", addr_log.size(), exp_q.size(), busy);
        end
        ready_mode = 0;
    endtask

    task automatic test_zero_count();
        do_dump(32'h0000_5000, 16'd0, 0);
        checks++;
        if (done_cyc != 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL zero_done: cycle %0d count %0d required 1 1", done_cyc, done_cnt);
        end
        checks++;
        if (addr_log.size() != 0 || busy_at1 !== 1'b0) begin
            errors++;
            $display("FAIL zero_bus: transfers %0d busy %b required 0 0", addr_log.size(), busy_at1);
        end
    endtask

    task automatic test_reset_during_send();
        push_words(32'h0000_6000, 1);
        start_address = 32'h0000_6000;
        word_count    = 16'd1;
        start         = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 0; c < 20 && out_valid !== 1'b1; c++) @(negedge clock);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_reach_send: out_valid=%b required 1", out_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, done} !== 3'b000 || HTRANS !== 2'b00 || HADDR !== 32'h0 || out_byte !== 8'h00) begin
            errors++;
            $display("FAIL rst_async: valid/busy/done=%b HTRANS=%b HADDR=%h byte=%h required 000 00 0 00",
                     {out_valid, busy, done}, HTRANS, HADDR, out_byte);
        end
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_done: done=%b busy=%b required 0 0", done, busy);
        end
        push_words(32'h0000_1002, 1);
        do_dump(32'h0000_1002, 16'd1, 0);
        checks++;
        if (done_cyc != 7 || exp_q.size() != 0 || addr_log.size() != 1) begin
            errors++;
            $display("FAIL rst_restart: cycle %0d left %0d transfers %0d required 7 0 1", done_cyc, exp_q.size(), addr_log.size());
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        start_address = 32'h0;
        word_count    = 16'd0;
        out_ready     = 1'b1;
        HRDATA        = 32'h0;
        HREADY        = 1'b1;
        HRESP         = 1'b0;
        fork
            slave_proc();
            consumer_proc();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_ready_toggle();
        test_zero_count();
        test_reset_during_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
